// File: rtl/stopwatch_pkg.sv
// Shared types and default limits for the MM:SS stopwatch/timer core.
// Pure declarations: no logic, no latency, no flow control.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        SET   = 2'd2,
        DONE  = 2'd3
    } sw_state_t;

    localparam int SEC_MAX_DEF     = 59;
    localparam int MIN_MAX_DEF     = 59;
    localparam int BLINK_TICKS_DEF = 4;

    // Width of a modulo-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/display bundle between the tick sources, the stopwatch core and the display.
// Level and single-cycle pulse signals only; there is no backpressure on this bus.
interface stopwatch_core_if #(
    parameter int SEC_W = 6,
    parameter int MIN_W = 6
);
    logic             count_tick;
    logic             adj_tick;
    logic             adj;
    logic             sel;
    logic             pause_pulse;
    logic             clear;
    logic             down_mode;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [1:0]       blink;
    logic             running;
    logic             done;

    modport master (
        output count_tick, adj_tick, adj, sel, pause_pulse, clear, down_mode,
        input  min, sec, blink, running, done
    );

    modport slave (
        input  count_tick, adj_tick, adj, sel, pause_pulse, clear, down_mode,
        output min, sec, blink, running, done
    );
endinterface

// File: rtl/sw_field_counter.sv
// One time field (seconds or minutes): load zero/max, increment or decrement with optional wrap.
// Value registered, 1-cycle latency; at_max/at_zero decode the current value; no backpressure.
module sw_field_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         wrap_en,
    input  logic         ld_zero,
    input  logic         ld_max,
    output logic [W-1:0] value,
    output logic         at_max,
    output logic         at_zero
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign at_max  = (value_q == MAX_V);
    assign at_zero = (value_q == '0);
    assign value   = value_q;

    // Without wrap_en a bound simply holds; the caller decides what happens there.
    always_comb begin
        value_d = value_q;
        if (ld_zero) begin
            value_d = '0;
        end else if (ld_max) begin
            value_d = MAX_V;
        end else if (inc) begin
            if (at_max) value_d = wrap_en ? '0 : value_q;
            else        value_d = value_q + 1'b1;
        end else if (dec) begin
            if (at_zero) value_d = wrap_en ? MAX_V : value_q;
            else         value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) value_q <= '0;
        else          value_q <= value_d;
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch/timer: RUN/PAUSE/SET/DONE control, direction latch and SET-mode blink divider.
// All outputs registered (1-cycle latency from tick/pulse); inputs are enables, no backpressure.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int SEC_MAX     = SEC_MAX_DEF,
    parameter int MIN_MAX     = MIN_MAX_DEF,
    parameter int SEC_W       = 6,
    parameter int MIN_W       = 6,
    parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_core_if.slave  bus
);
    localparam int           BW      = cnt_w(BLINK_TICKS);
    localparam logic [BW-1:0] BT_LAST = BW'(BLINK_TICKS - 1);

    sw_state_t state_q, state_d;
    logic      dir_q, dir_d;            // 1 = counting down
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic      phase_q, phase_d;
    logic [1:0] blink_q, blink_d;

    logic sec_inc, sec_dec, sec_wrap, sec_ldz, sec_ldmax;
    logic min_inc, min_dec, min_wrap, min_ldz;
    logic [SEC_W-1:0] sec_val;
    logic [MIN_W-1:0] min_val;
    logic sec_at_max, sec_at_zero, min_at_max, min_at_zero;
    logic sec_is_one;
    logic set_tick;
    logic enter_set;

    assign sec_is_one = (sec_val == SEC_W'(1));

    sw_field_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (sec_inc),
        .dec     (sec_dec),
        .wrap_en (sec_wrap),
        .ld_zero (sec_ldz),
        .ld_max  (sec_ldmax),
        .value   (sec_val),
        .at_max  (sec_at_max),
        .at_zero (sec_at_zero)
    );

    sw_field_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (min_inc),
        .dec     (min_dec),
        .wrap_en (min_wrap),
        .ld_zero (min_ldz),
        .ld_max  (1'b0),
        .value   (min_val),
        .at_max  (min_at_max),
        .at_zero (min_at_zero)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        sec_inc   = 1'b0;
        sec_dec   = 1'b0;
        sec_wrap  = 1'b0;
        sec_ldz   = 1'b0;
        sec_ldmax = 1'b0;
        min_inc   = 1'b0;
        min_dec   = 1'b0;
        min_wrap  = 1'b0;
        min_ldz   = 1'b0;
        set_tick  = 1'b0;

        // clear owns the whole cycle: every other request and tick is dropped.
        if (bus.clear) begin
            sec_ldz = 1'b1;
            min_ldz = 1'b1;
            if (state_q == DONE) state_d = PAUSE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.adj) begin
                        state_d = SET;
                    end else if (bus.pause_pulse) begin
                        state_d = PAUSE;
                    end else if (bus.count_tick) begin
                        if (!dir_q) begin
                            if (sec_at_max) begin
                                if (min_at_max) begin
                                    state_d = DONE;
                                end else begin
                                    sec_inc  = 1'b1;
                                    sec_wrap = 1'b1;
                                    min_inc  = 1'b1;
                                end
                            end else begin
                                sec_inc = 1'b1;
                            end
                        end else begin
                            if (sec_at_zero) begin
                                if (min_at_zero) begin
                                    state_d = DONE;
                                end else begin
                                    sec_ldmax = 1'b1;
                                    min_dec   = 1'b1;
                                end
                            end else begin
                                sec_dec = 1'b1;
                                if (min_at_zero && sec_is_one) state_d = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.adj) begin
                        state_d = SET;
                    end else if (bus.pause_pulse) begin
                        dir_d = bus.down_mode;
                        // A down-count from 00:00 has nothing to run; finish at once.
                        if (bus.down_mode && sec_at_zero && min_at_zero) state_d = DONE;
                        else                                            state_d = RUN;
                    end
                end
                SET: begin
                    if (!bus.adj) begin
                        state_d = PAUSE;
                    end else if (bus.adj_tick) begin
                        set_tick = 1'b1;
                        if (bus.sel) begin
                            sec_inc  = 1'b1;
                            sec_wrap = 1'b1;
                        end else begin
                            min_inc  = 1'b1;
                            min_wrap = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.adj)              state_d = SET;
                    else if (bus.pause_pulse) state_d = PAUSE;
                end
                default: state_d = PAUSE;
            endcase
        end
    end

    assign enter_set = (state_d == SET) && (state_q != SET);

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (enter_set) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (set_tick) begin
            if (bcnt_q == BT_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        // Only the field being adjusted blinks: {min_blank, sec_blank}.
        blink_d = 2'b00;
        if (state_d == SET) blink_d = bus.sel ? {1'b0, phase_d} : {phase_d, 1'b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PAUSE;
            dir_q   <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            blink_q <= 2'b00;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
        end
    end

    assign bus.min     = min_val;
    assign bus.sec     = sec_val;
    assign bus.blink   = blink_q;
    assign bus.running = (state_q == RUN);
    assign bus.done    = (state_q == DONE);

endmodule
